// File: rtl/serial_pattern_transmitter.sv
// Serial bit-pattern transmitter: captures a pattern/length/repeat on start and
// shifts it out MSB-first, one bit per clock, with a one-cycle gap between frames.
module serial_pattern_transmitter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] length_i,
  input  logic [REP_W-1:0] repeat_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;

  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             len_ok;
  logic             last_bit;
  logic [WIDTH-1:0] aligned;

  // Left-align the pattern so bit [length-1] sits in the MSB of the shifter.
  always_comb begin
    len_ok   = (length_i != '0) && (32'(length_i) <= WIDTH);
    aligned  = pattern_i << (WIDTH - 32'(length_i));
    last_bit = (cnt_q == (len_q - LEN_W'(1)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rep_d    = rep_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && len_ok) begin
          shift_d  = aligned;
          shadow_d = aligned;
          len_d    = length_i;
          rep_d    = repeat_i;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (abort_i) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (last_bit) begin
          state_d = (rep_q != '0) ? GAP : DONE;
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      GAP: begin
        if (abort_i) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else begin
          rep_d   = rep_q - REP_W'(1);
          shift_d = shadow_q;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      DONE: begin
        cnt_d   = '0;
        rep_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so every port comes straight off a flop.
  always_comb begin
    x_d       = (state_d == SEND) && shift_d[WIDTH-1];
    x_valid_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    err_d     = (state_q == IDLE) && start_i && !len_ok;
  end

  assign x_o       = x_q;
  assign x_valid_o = x_valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Directed self-checking bench for serial_pattern_transmitter; outputs are
// compared as the packed vector {x, x_valid, busy, done, err}.
module tb_serial_pattern_transmitter;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic [REP_W-1:0] rep;
  logic             x, x_valid, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  serial_pattern_transmitter #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .REP_W(REP_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start_i  (start),
    .abort_i  (abort),
    .pattern_i(pattern),
    .length_i (length),
    .repeat_i (rep),
    .x_o      (x),
    .x_valid_o(x_valid),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {x, x_valid, busy, done, err};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives start in the current cycle (cycle 0); returns positioned in cycle 1.
  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [2:0] r);
    pattern = p;
    length  = l;
    rep     = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin : main
    logic [4:0] single_e [4];
    logic       a5_bits  [8];
    logic [4:0] e;

    single_e = '{5'b01100, 5'b11100, 5'b01100, 5'b00110};
    a5_bits  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset   = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    pattern = 8'($urandom);
    length  = 4'd3;
    rep     = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset_hold_%0d", i), outs(), 5'b00000);
    end
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset_%0d", i), outs(), 5'b00000);
    end

    // Single frame "010"
    launch(8'h02, 4'd3, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("single_c%0d", c), outs(), single_e[c-1]);
      if (c < 4) tick();
    end
    tick();
    chk("single_c5_idle", outs(), 5'b00000);

    // Back-to-back: start in the IDLE cycle right after DONE, two frames of A5
    launch(8'hA5, 4'd8, 3'd1);
    for (int c = 1; c <= 19; c++) begin
      if (c <= 8)       e = {a5_bits[c-1], 4'b1100};
      else if (c == 9)  e = 5'b00100;
      else if (c <= 17) e = {a5_bits[c-10], 4'b1100};
      else if (c == 18) e = 5'b00110;
      else              e = 5'b00000;
      chk($sformatf("rep_c%0d", c), outs(), e);
      if (c < 19) tick();
    end

    // Rejected starts
    launch(8'h5A, 4'd0, 3'd0);
    chk("rej_len0_c1", outs(), 5'b00001);
    tick();
    chk("rej_len0_c2", outs(), 5'b00000);
    launch(8'h5A, 4'd9, 3'd2);
    chk("rej_len9_c1", outs(), 5'b00001);
    tick();
    chk("rej_len9_c2", outs(), 5'b00000);
    launch(8'h01, 4'd1, 3'd0);
    chk("len1_c1", outs(), 5'b11100);
    tick();
    chk("len1_c2", outs(), 5'b00110);
    tick();
    chk("len1_c3", outs(), 5'b00000);

    // Start pulse and pattern change during a frame are ignored
    launch(8'h02, 4'd3, 3'd0);
    chk("ign_c1", outs(), 5'b01100);
    tick();
    chk("ign_c2", outs(), 5'b11100);
    start   = 1'b1;
    pattern = 8'hFF;
    tick();
    start   = 1'b0;
    chk("ign_c3", outs(), 5'b01100);
    tick();
    chk("ign_c4", outs(), 5'b00110);
    tick();
    chk("ign_c5", outs(), 5'b00000);
    tick();
    chk("ign_c6", outs(), 5'b00000);

    // Abort mid-frame
    launch(8'h02, 4'd3, 3'd0);
    chk("abort_c1", outs(), 5'b01100);
    tick();
    chk("abort_c2", outs(), 5'b11100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_c3", outs(), 5'b00000);
    tick();
    chk("abort_c4", outs(), 5'b00000);
    tick();
    chk("abort_c5", outs(), 5'b00000);

    // Start and abort together in IDLE: start wins
    abort = 1'b1;
    launch(8'h02, 4'd3, 3'd0);
    abort = 1'b0;
    chk("sa_c1", outs(), 5'b01100);
    tick();
    chk("sa_c2", outs(), 5'b11100);
    tick();
    chk("sa_c3", outs(), 5'b01100);
    tick();
    chk("sa_c4", outs(), 5'b00110);
    tick();

    // Asynchronous reset in the middle of GAP
    launch(8'hA5, 4'd8, 3'd1);
    for (int c = 1; c < 9; c++) tick();
    chk("gap_before_reset", outs(), 5'b00100);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_now", outs(), 5'b00000);
    tick();
    reset = 1'b1;
    chk("async_reset_held", outs(), 5'b00000);
    tick();
    chk("async_reset_after", outs(), 5'b00000);
    tick();
    chk("async_reset_after2", outs(), 5'b00000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_transmitter.md
# serial_pattern_transmitter

Serial bit-pattern transmitter: the driving end of the single-bit serial line that the sequence recognizer samples on x. It captures a parallel pattern, a bit length and a repeat count on a start pulse. It then shifts the pattern out MSB-first, one bit per clock, with a qualifying valid strobe. It sits in front of the recognizer in the lab top level and serves as the stimulus source for its testbench.

## Interface
- WIDTH, 8: pattern register width in bits, legal 2..16.
- LEN_W, 4: width of the length port; 2^LEN_W > WIDTH is required.
- REP_W, 3: width of the repeat port.
- clock  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel; ignored in IDLE.
- pattern  input  WIDTH  bits to send; bit [length-1] goes first.
- length  input  LEN_W  number of bits per frame, legal 1..WIDTH.
- repeat  input  REP_W  number of extra frames after the first; 0 means send once.
- x  output  1  serial data, registered.
- x_valid  output  1  high while x carries a pattern bit.
- busy  output  1  high from the first SEND cycle through the DONE cycle.
- done  output  1  single-cycle pulse after the last bit of the last frame.
- err  output  1  single-cycle pulse on a rejected start.

## Operation
- States: IDLE, SEND, GAP, DONE (2-bit encoding).
- Internal registers: shift register (WIDTH), bit counter (LEN_W), repeat counter (REP_W), shadow copy of the pattern for reload.
- IDLE, start=1, length in 1..WIDTH:
  - Capture pattern, length and repeat.
  - Go to SEND.
  - Later changes on the inputs have no effect until the next IDLE.
- IDLE, start=1, length=0 or length>WIDTH:
  - err=1 for one cycle.
  - State stays IDLE; nothing is captured.
- SEND:
  - x = current MSB-aligned bit, x_valid=1.
  - Shift by one bit and increment the bit counter each cycle.
  - After the length-th bit: go to GAP if the repeat counter is nonzero, otherwise go to DONE.
- GAP (exactly one cycle):
  - x=0, x_valid=0.
  - Decrement the repeat counter, reload the shift register from the shadow copy, clear the bit counter.
  - Then go to SEND.
- DONE (exactly one cycle): done=1, x=0, x_valid=0, then go to IDLE.
- abort=1 in SEND or GAP:
  - Next state is IDLE; x and x_valid are 0 from the next cycle.
  - No done pulse.
  - Counters clear on entry to IDLE.
- abort=1 in DONE: ignored; the done pulse completes.
- start while busy=1 or in DONE: ignored; it is not queued, and err is not raised.
- start and abort together in IDLE: start is accepted and abort is ignored.
- In IDLE: x=0, x_valid=0, busy=0.

## Timing
- Reset is asynchronous. It forces state=IDLE, all counters to 0, and x, x_valid, busy, done and err to 0 immediately. It is legal mid-frame; the transfer is lost.
- All outputs are registered; none depends combinationally on inputs.
- Cycle numbering: start is sampled high at the edge ending cycle 0.
  - First bit appears in cycle 1.
  - Frame f (0-based) occupies cycles 1+f*(L+1) through f*(L+1)+L, where L = length.
  - GAP cycles fall between frames.
- With N = repeat+1:
  - done fires in cycle N*L+N.
  - busy is high in cycles 1 through N*L+N.
  - IDLE is back in cycle N*L+N+1, and a start in that cycle is accepted.
- err fires in cycle 1 for a rejected start; busy stays 0.
- Maximum throughput is one bit per clock within a frame, with one dead cycle between frames.

## Test plan
- Reset: hold reset=0 with start=1 and random inputs. Required: x, x_valid, busy, done and err all 0. After release, all stay 0 until a start.
- Single frame, "010" into the recognizer: pattern=8'h02, length=3, repeat=0, start in cycle 0.
  - Required: x=0,1,0 in cycles 1..3 with x_valid=1.
  - done=1 in cycle 4; busy=1 in cycles 1..4.
  - Recognizer z=1 during cycle 3.
- Repeat: pattern=8'hA5, length=8, repeat=1.
  - Required: x=1,0,1,0,0,1,0,1 in cycles 1..8.
  - GAP in cycle 9 with x_valid=0.
  - Same bits again in cycles 10..17; done in cycle 18.
- Rejected start:
  - length=0 -> err=1 in cycle 1, busy=0, x_valid=0.
  - Repeat with length=9 -> same response.
  - Then length=1, pattern=1 -> x=1 in cycle 1, done in cycle 2.
- Ignored inputs: during the frame of the single-frame case, pulse start and change pattern to 8'hFF in cycle 2. Required: output bits are unchanged, no err, a single done in cycle 4.
- Abort and async reset:
  - abort=1 in cycle 2 of the single-frame case -> x_valid=0 and busy=0 from cycle 3, no done.
  - Separately, drop reset mid-GAP -> outputs are 0 immediately.
